// File: rtl/rc5_key_expand_if.sv
// Request/status/read-port bundle between the RC5-16 key-schedule engine and its users.
interface rc5_key_expand_if;
    logic         start;
    logic [4:0]   num_rounds;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         err;
    logic         valid;
    logic [6:0]   t_words;
    logic [5:0]   s_rd_addr;
    logic [15:0]  s_rd_data;

    modport master (
        output start, num_rounds, key, s_rd_addr,
        input  busy, done, err, valid, t_words, s_rd_data
    );

    modport slave (
        input  start, num_rounds, key, s_rd_addr,
        output busy, done, err, valid, t_words, s_rd_data
    );
endinterface

// File: rtl/rc5_key_expand.sv
// RC5-16/r/16 key schedule: expands a 128-bit key into S[0..t-1] and serves it
// through an asynchronous read port to the round datapath.
module rc5_key_expand (
    input  logic             clk,
    input  logic             rst,
    rc5_key_expand_if.slave  bus
);

    localparam int unsigned W       = 16;
    localparam logic [W-1:0] P_CONST = 16'hB7E1;
    localparam logic [W-1:0] Q_CONST = 16'h9E37;
    localparam int unsigned MAX_T   = 64;
    localparam int unsigned C_WORDS = 8;
    localparam int unsigned AW      = 6;
    localparam int unsigned TW      = 7;
    localparam int unsigned NW      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic [TW-1:0]  t_words_q, t_words_d;

    logic [TW-1:0]  t_lat_q;
    logic [AW-1:0]  k_q;
    logic [AW-1:0]  i_q;
    logic [2:0]     j_q;
    logic [NW-1:0]  n_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   init_val_q;

    logic [W-1:0]   s_mem [MAX_T];
    logic [W-1:0]   l_mem [C_WORDS];

    logic           accept;
    logic           rounds_zero;
    logic           init_last;
    logic           mix_last;
    logic [8:0]     t_x3;
    logic [NW-1:0]  n_last;
    logic [AW-1:0]  i_next;
    logic [W-1:0]   sum_a, a_new, ab_sum, sum_b, b_new;

    // Left rotate by 0..15; the doubled word makes rotate-by-zero fall out naturally.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [3:0] amt);
        logic [2*W-1:0] d;
        d = {x, x} << amt;
        return d[2*W-1:W];
    endfunction

    // Control decodes and the single-cycle mixing step (a' feeds b' in the same cycle).
    always_comb begin
        accept      = (state_q == IDLE) && bus.start;
        rounds_zero = (bus.num_rounds == 5'd0);
        init_last   = ({1'b0, k_q} == (t_lat_q - 7'd1));
        t_x3        = 9'(t_lat_q) * 9'd3;
        n_last      = (t_lat_q < 7'd8) ? 8'd23 : 8'(t_x3 - 9'd1);
        mix_last    = (n_q == n_last);
        i_next      = (({1'b0, i_q} + 7'd1) == t_lat_q) ? '0 : i_q + 6'd1;
        sum_a       = s_mem[i_q] + a_q + b_q;
        a_new       = {sum_a[W-4:0], sum_a[W-1:W-3]};
        ab_sum      = a_new + b_q;
        sum_b       = l_mem[j_q] + ab_sum;
        b_new       = rotl(sum_b, ab_sum[3:0]);
    end

    // Next-state and registered-output targets.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = err_q;
        valid_d   = valid_q;
        t_words_d = t_words_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d     = 1'b0;
                    valid_d   = 1'b0;
                    t_words_d = '0;
                    if (rounds_zero) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                if (init_last) state_d = MIX;
            end
            MIX: begin
                if (mix_last) state_d = DONE;
            end
            DONE: begin
                done_d    = 1'b1;
                valid_d   = 1'b1;
                t_words_d = t_lat_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == INIT) || (state_d == MIX);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            t_words_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            t_words_q <= t_words_d;
        end
    end

    // Expansion working registers: latched t, counters, A/B and the INIT progression.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_lat_q    <= '0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            n_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            init_val_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && !rounds_zero) begin
                        t_lat_q    <= {1'b0, bus.num_rounds, 1'b0} + 7'd2;
                        k_q        <= '0;
                        init_val_q <= P_CONST;
                    end
                end
                INIT: begin
                    k_q        <= k_q + 6'd1;
                    init_val_q <= init_val_q + Q_CONST;
                    if (init_last) begin
                        a_q <= '0;
                        b_q <= '0;
                        i_q <= '0;
                        j_q <= '0;
                        n_q <= '0;
                    end
                end
                MIX: begin
                    a_q <= a_new;
                    b_q <= b_new;
                    i_q <= i_next;
                    j_q <= j_q + 3'd1;
                    n_q <= n_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // S and L storage; contents are meaningless until valid so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned m = 0; m < C_WORDS; m++) begin
                l_mem[m] <= bus.key[W*m +: W];
            end
        end
        if (state_q == INIT) begin
            s_mem[k_q] <= init_val_q;
        end
        if (state_q == MIX) begin
            s_mem[i_q] <= a_new;
            l_mem[j_q] <= b_new;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.valid     = valid_q;
    assign bus.t_words   = t_words_q;
    assign bus.s_rd_data = (valid_q && ({1'b0, bus.s_rd_addr} < t_words_q))
                           ? s_mem[bus.s_rd_addr] : '0;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand: latency, status flags and the full S table
// against a straightforward RC5-16 reference schedule.
module tb_rc5_key_expand;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] exp_s [64];

    rc5_key_expand_if bus ();

    rc5_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] x, input int s);
        int sh;
        sh = s & 15;
        if (sh == 0) return x;
        return (x << sh) | (x >> (16 - sh));
    endfunction

    // Reference RC5 key schedule, written as the textbook three-loop form.
    task automatic run_model(input logic [127:0] k, input int r);
        logic [15:0] l [8];
        logic [15:0] a, b;
        int t, iters, ii, jj;
        t = 2 * r + 2;
        exp_s[0] = 16'hB7E1;
        for (int q = 1; q < 64; q++) exp_s[q] = exp_s[q-1] + 16'h9E37;
        for (int m = 0; m < 8; m++) l[m] = k[16*m +: 16];
        a = 16'h0; b = 16'h0; ii = 0; jj = 0;
        iters = 3 * ((t > 8) ? t : 8);
        for (int n = 0; n < iters; n++) begin
            a = rol(16'(exp_s[ii] + a + b), 3);
            exp_s[ii] = a;
            b = rol(16'(l[jj] + a + b), int'(16'(a + b) & 16'hF));
            l[jj] = b;
            ii = (ii + 1) % t;
            jj = (jj + 1) % 8;
        end
    endtask

    // Issue a one-cycle start from the current negedge; returns at the next negedge.
    task automatic kick(input logic [4:0] r, input logic [127:0] k);
        bus.start      = 1'b1;
        bus.num_rounds = r;
        bus.key        = k;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] r, input logic [127:0] k);
        @(negedge clk);
        kick(r, k);
    endtask

    // Cycle 0 is the negedge after the accepting edge; bounded by max_cyc.
    task automatic wait_done(input int max_cyc, input bit noisy, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (cyc < max_cyc) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
            if (cyc == 3 && bus.busy) begin
                bus.s_rd_addr = 6'd0;
                #1;
                check("read_while_busy", 32'(bus.s_rd_data), 32'd0);
            end
            if (noisy) begin
                bus.start      = cyc[0];
                bus.num_rounds = 5'($urandom);
                bus.key        = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        if (noisy) bus.start = 1'b0;
    endtask

    task automatic check_table(input int t, input string tag);
        for (int a = 0; a < 64; a++) begin
            bus.s_rd_addr = 6'(a);
            #1;
            check($sformatf("%s_s%0d", tag, a), 32'(bus.s_rd_data),
                  (a < t) ? 32'(exp_s[a]) : 32'd0);
        end
    endtask

    task automatic check_status(input string tag, input int cyc, input int exp_cyc,
                                input int t, input logic [31:0] exp_t);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_t_words"}, 32'(bus.t_words), exp_t);
        check({tag, "_t_int"}, 32'(t), exp_t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcnt, dcnt;
        logic [127:0] k12, k31, k2, ka;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.num_rounds = 5'd0;
        bus.key = '0;
        bus.s_rd_addr = 6'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_t_words", 32'(bus.t_words), 32'd0);
        check("rst_rd_data", 32'(bus.s_rd_data), 32'd0);
        rst = 1'b1;

        // Zero key, r=1
        run_model('0, 1);
        start_run(5'd1, '0);
        wait_done(400, 1'b0, cyc, bcnt);
        check("r1_busy_cycles", 32'(bcnt), 32'd28);
        check_status("r1", cyc, 29, 4, 32'd4);
        @(negedge clk);
        check("r1_done_pulse", 32'(bus.done), 32'd0);
        check_table(4, "r1");

        // Byte-ramp key, r=12
        k12 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        run_model(k12, 12);
        start_run(5'd12, k12);
        check("r12_valid_drop", 32'(bus.valid), 32'd0);
        wait_done(400, 1'b0, cyc, bcnt);
        check_status("r12", cyc, 105, 26, 32'd26);
        check_table(26, "r12");

        // Random key, r=31, then r=2 and a start right in the done cycle
        k31 = {$urandom, $urandom, $urandom, $urandom};
        run_model(k31, 31);
        start_run(5'd31, k31);
        wait_done(400, 1'b0, cyc, bcnt);
        check_status("r31", cyc, 257, 64, 32'd64);
        check_table(64, "r31");

        k2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        run_model(k2, 2);
        start_run(5'd2, k2);
        check("r2_valid_drop", 32'(bus.valid), 32'd0);
        check("r2_t_words_drop", 32'(bus.t_words), 32'd0);
        wait_done(400, 1'b0, cyc, bcnt);
        check_status("r2", cyc, 31, 6, 32'd6);
        run_model('0, 1);
        kick(5'd1, '0);
        check("back2back_valid_drop", 32'(bus.valid), 32'd0);
        check("back2back_busy", 32'(bus.busy), 32'd1);
        wait_done(400, 1'b0, cyc, bcnt);
        check_status("back2back", cyc, 29, 4, 32'd4);
        check_table(4, "back2back");

        // Rejected request: num_rounds == 0
        start_run(5'd0, k12);
        check("rej_done", 32'(bus.done), 32'd1);
        check("rej_err", 32'(bus.err), 32'd1);
        check("rej_valid", 32'(bus.valid), 32'd0);
        check("rej_t_words", 32'(bus.t_words), 32'd0);
        dcnt = 0;
        bcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
        check("rej_extra_done", 32'(dcnt), 32'd0);
        check("rej_busy_cnt", 32'(bcnt), 32'd0);
        check("rej_err_sticky", 32'(bus.err), 32'd1);

        // Reset in the middle of an r=20 run
        start_run(5'd20, k31);
        check("r20_err_cleared", 32'(bus.err), 32'd0);
        repeat (40) @(negedge clk);
        check("r20_busy_before_rst", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_model('0, 1);
        start_run(5'd1, '0);
        wait_done(400, 1'b0, cyc, bcnt);
        check("postrst_busy_cycles", 32'(bcnt), 32'd28);
        check_status("postrst", cyc, 29, 4, 32'd4);
        check_table(4, "postrst");

        // Start and inputs thrashing while busy: original request must win
        ka = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;
        run_model(ka, 5);
        start_run(5'd5, ka);
        wait_done(400, 1'b1, cyc, bcnt);
        check_status("noisy", cyc, 49, 12, 32'd12);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("noisy_single_done", 32'(dcnt), 32'd0);
        check("noisy_idle_busy", 32'(bus.busy), 32'd0);
        check_table(12, "noisy");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
